// File: rtl/alu_muldiv.sv
// alu_muldiv: sequential signed multiply/divide unit, one radix-2 step per cycle over operand magnitudes.
module alu_muldiv #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] op1,
   input  logic [WIDTH-1:0] op2,
   input  logic [5:0]       alu_funct,
   output logic             busy,
   output logic             done,
   output logic [WIDTH:0]   alu_res,
   output logic [4:0]       flags
);
   localparam logic [5:0] FN_MUL  = 6'h18;
   localparam logic [5:0] FN_MULH = 6'h19;
   localparam logic [5:0] FN_DIV  = 6'h1A;
   localparam logic [5:0] FN_REM  = 6'h1B;
   localparam int FL_ZERO     = 0;
   localparam int FL_TRUE     = 1;
   localparam int FL_NEG      = 2;
   localparam int FL_OVERFLOW = 3;
   localparam int FL_NEGZERO  = 4;
   localparam int CW = $clog2(WIDTH);
   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
   state_t state;
   logic [CW-1:0] cnt;
   logic [5:0] fn;
   logic s1, s2;
   logic [WIDTH-1:0] a, b;
   logic [2*WIDTH-1:0] p;
   logic [WIDTH-1:0] m1, m2, dt, quo, rem, res, z_res;
   logic [WIDTH:0] msum;
   logic [2*WIDTH-1:0] prod;
   logic ge, ovf, is_mul, in_mul, in_div;
   function automatic logic [4:0] mk_flags(input logic [WIDTH-1:0] r, input logic o);
      mk_flags = '0;
      mk_flags[FL_ZERO] = ~|r;
      mk_flags[FL_TRUE] = 1'b0;
      mk_flags[FL_NEG] = r[WIDTH-1];
      mk_flags[FL_OVERFLOW] = o;
      mk_flags[FL_NEGZERO] = ~|r | r[WIDTH-1];
   endfunction
   // p holds {acc, multiplier} for multiply and {partial remainder, dividend/quotient} for divide
   always_comb begin
      m1 = op1[WIDTH-1] ? -op1 : op1;
      m2 = op2[WIDTH-1] ? -op2 : op2;
      in_mul = alu_funct == FN_MUL || alu_funct == FN_MULH;
      in_div = alu_funct == FN_DIV || alu_funct == FN_REM;
      z_res = alu_funct == FN_DIV ? '1 : op1;
      is_mul = fn == FN_MUL || fn == FN_MULH;
      msum = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, a} : '0);
      ge = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]} >= {1'b0, b};
      dt = {p[2*WIDTH-2:WIDTH], p[WIDTH-1]} - b;
      prod = (s1 ^ s2) ? -p : p;
      quo = (s1 ^ s2) ? -p[WIDTH-1:0] : p[WIDTH-1:0];
      rem = s1 ? -p[2*WIDTH-1:WIDTH] : p[2*WIDTH-1:WIDTH];
      res = fn == FN_MUL ? prod[WIDTH-1:0] : fn == FN_MULH ? prod[2*WIDTH-1:WIDTH] : fn == FN_DIV ? quo : rem;
      ovf = fn == FN_MUL ? prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}} :
            fn == FN_DIV ? s1 & s2 & (a == {1'b1, {(WIDTH-1){1'b0}}}) & (b == WIDTH'(1)) : 1'b0;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         busy <= 1'b0;
         done <= 1'b0;
         alu_res <= '0;
         flags <= '0;
         cnt <= '0;
         fn <= '0;
         s1 <= 1'b0;
         s2 <= 1'b0;
         a <= '0;
         b <= '0;
         p <= '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               fn <= alu_funct;
               s1 <= op1[WIDTH-1];
               s2 <= op2[WIDTH-1];
               a <= m1;
               b <= m2;
               cnt <= CW'(WIDTH-1);
               busy <= 1'b1;
               if (in_mul) begin
                  p <= {{WIDTH{1'b0}}, m2};
                  state <= CALC;
               end else if (in_div && op2 != '0) begin
                  p <= {{WIDTH{1'b0}}, m1};
                  state <= CALC;
               end else begin
                  alu_res <= in_div ? {1'b0, z_res} : '0;
                  flags <= in_div ? mk_flags(z_res, 1'b1) : '0;
                  done <= 1'b1;
                  state <= DONE;
               end
            end
            CALC: begin
               p <= is_mul ? {msum, p[WIDTH-1:1]} :
                    ge ? {dt, p[WIDTH-2:0], 1'b1} : {p[2*WIDTH-2:0], 1'b0};
               cnt <= cnt - 1'b1;
               if (cnt == '0) state <= FIX;
            end
            FIX: begin
               alu_res <= {1'b0, res};
               flags <= mk_flags(res, ovf);
               done <= 1'b1;
               state <= DONE;
            end
            DONE: begin
               done <= 1'b0;
               busy <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end
endmodule
